// File: rtl/alu_adder_hold.sv
// alu_adder_hold: 6502-style ALU with the adder hold register (ADD) and its
// registered carry (ACR), overflow (AVR) and half carry (HC).
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   a_in, b_in    A / B input register values (caller supplies ~DB for SBC)
//   alu_enable    latch strobe for the selected operation
//   sums/ands/eors/ors/srs  operation selects, priority in that order
//   i_addc        carry in; also the bit shifted into the MSB by srs
//   daa, dsa      decimal add / subtract adjust (only with sums)
//   add_out       adder hold register
//   acr, avr, hc  registered carry, overflow, half carry
//   result_valid  one-cycle pulse when add_out and the flags are final
//   busy          decimal correction in progress
//
// Optional feature: define DECIMAL_MODE_EN to enable the second-cycle BCD
// correction. Without it daa/dsa are ignored (2A03 behaviour) and busy is 0.
module alu_adder_hold #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] HOLD_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             alu_enable,
  input  logic             sums,
  input  logic             ands,
  input  logic             eors,
  input  logic             ors,
  input  logic             srs,
  input  logic             i_addc,
  input  logic             daa,
  input  logic             dsa,
  output logic [WIDTH-1:0] add_out,
  output logic             acr,
  output logic             avr,
  output logic             hc,
  output logic             result_valid,
  output logic             busy
);

  logic [WIDTH:0]   w_sum;
  logic [4:0]       w_hsum;
  logic [WIDTH-1:0] w_res;
  logic             w_acr, w_avr, w_hc;
  logic             w_any_sel;

  logic [WIDTH-1:0] r_add;
  logic             r_acr, r_avr, r_hc, r_valid, r_busy;

  assign w_sum  = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, i_addc};
  assign w_hsum = {1'b0, a_in[3:0]} + {1'b0, b_in[3:0]} + {4'b0, i_addc};
  assign w_any_sel = sums | ands | eors | ors | srs;

  // Result mux; priority sums > ands > eors > ors > srs.
  always_comb begin
    w_res = r_add;
    w_acr = 1'b0;
    w_avr = 1'b0;
    w_hc  = 1'b0;
    if (sums) begin
      w_res = w_sum[WIDTH-1:0];
      w_acr = w_sum[WIDTH];
      w_avr = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (w_sum[WIDTH-1] != a_in[WIDTH-1]);
      w_hc  = w_hsum[4];
    end else if (ands) begin
      w_res = a_in & b_in;
    end else if (eors) begin
      w_res = a_in ^ b_in;
    end else if (ors) begin
      w_res = a_in | b_in;
    end else if (srs) begin
      w_res = {i_addc, a_in[WIDTH-1:1]};
      w_acr = a_in[0];
    end
  end

`ifdef DECIMAL_MODE_EN
  typedef enum logic {IDLE, CORRECT} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_dsa;
  logic             w_latch, w_dec_req;
  logic [WIDTH-1:0] w_t1, w_cor;
  logic             w_cor_acr;

  assign w_latch   = alu_enable & w_any_sel & (r_state == IDLE);
  // daa and dsa together are treated as a plain binary add.
  assign w_dec_req = w_latch & sums & (daa ^ dsa);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_dec_req) w_state_nxt = CORRECT;
      CORRECT: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // BCD correction applied to the raw result held in ADD.
  always_comb begin
    w_t1      = r_add;
    w_cor     = r_add;
    w_cor_acr = r_acr;
    if (!r_dsa) begin
      // daa: low-nibble +6 carries into the high nibble before it is tested.
      if (r_hc || (r_add[3:0] > 4'd9)) w_t1 = r_add + WIDTH'(6);
      w_cor = w_t1;
      if (r_acr || (w_t1[7:4] > 4'd9)) begin
        w_cor     = w_t1 + WIDTH'(8'h60);
        w_cor_acr = 1'b1;
      end
    end else begin
      // dsa: each nibble adjusted independently, no borrow between them.
      w_cor[3:0] = r_hc  ? r_add[3:0] : r_add[3:0] - 4'd6;
      w_cor[7:4] = r_acr ? r_add[7:4] : r_add[7:4] - 4'd6;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_add   <= HOLD_RESET;
      r_acr   <= 1'b0;
      r_avr   <= 1'b0;
      r_hc    <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_dsa   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == CORRECT) begin
        r_add   <= w_cor;
        r_acr   <= w_cor_acr;
        r_busy  <= 1'b0;
        r_valid <= 1'b1;
      end else if (w_latch) begin
        r_add   <= w_res;
        r_acr   <= w_acr;
        r_avr   <= w_avr;
        r_hc    <= w_hc;
        r_busy  <= w_dec_req;
        r_valid <= ~w_dec_req;
        r_dsa   <= dsa;
      end
    end
  end
`else
  logic w_latch;
  logic w_unused_dec;

  assign w_latch      = alu_enable & w_any_sel;
  assign w_unused_dec = daa | dsa;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_add   <= HOLD_RESET;
      r_acr   <= 1'b0;
      r_avr   <= 1'b0;
      r_hc    <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= w_latch;
      r_busy  <= 1'b0;
      if (w_latch) begin
        r_add <= w_res;
        r_acr <= w_acr;
        r_avr <= w_avr;
        r_hc  <= w_hc;
      end
    end
  end
`endif

  assign add_out      = r_add;
  assign acr          = r_acr;
  assign avr          = r_avr;
  assign hc           = r_hc;
  assign result_valid = r_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_alu_adder_hold.sv
// Scoreboard bench for alu_adder_hold: stimulus pushes hand-computed
// expected results, a monitor pops and compares on every result_valid.
module tb_alu_adder_hold;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       v;
    logic       h;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] a_in = '0, b_in = '0;
  logic       alu_enable = 0, sums = 0, ands = 0, eors = 0, ors = 0, srs = 0;
  logic       i_addc = 0, daa = 0, dsa = 0;
  logic [7:0] add_out;
  logic       acr, avr, hc, result_valid, busy;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  alu_adder_hold dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
    .alu_enable(alu_enable), .sums(sums), .ands(ands), .eors(eors),
    .ors(ors), .srs(srs), .i_addc(i_addc), .daa(daa), .dsa(dsa),
    .add_out(add_out), .acr(acr), .avr(avr), .hc(hc),
    .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every result_valid cycle must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: unexpected result add_out=%0h", add_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({add_out, acr, avr, hc} !== e) begin
            errors++;
            $display("FAIL scoreboard: got d=%0h c=%0b v=%0b h=%0b expected d=%0h c=%0b v=%0b h=%0b",
                     add_out, acr, avr, hc, e.d, e.c, e.v, e.h);
          end
        end
      end
    end
  end

  // sel = {sums, ands, eors, ors, srs}
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [4:0] sel, input logic da, input logic ds);
    a_in = a; b_in = b; i_addc = cin;
    {sums, ands, eors, ors, srs} = sel;
    daa = da; dsa = ds;
    alu_enable = 1'b1;
  endtask

  task automatic idle_in();
    alu_enable = 1'b0;
    {sums, ands, eors, ors, srs} = '0;
    daa = 1'b0; dsa = 1'b0;
  endtask

  // Strobe for one cycle; returns on the negedge after the latch edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [4:0] sel, input logic da, input logic ds);
    @(negedge clk);
    drive(a, b, cin, sel, da, ds);
    @(negedge clk);
    idle_in();
  endtask

  task automatic push(input logic [7:0] d, input logic c, input logic v, input logic h);
    exp_t e;
    e = '{d: d, c: c, v: v, h: h};
    q.push_back(e);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_state", {add_out, acr, avr, hc, result_valid, busy}, {8'h00, 5'b0});
    reset = 1'b1;

    // 0x50+0x50: signed overflow, single-cycle valid pulse
    push(8'hA0, 0, 1, 0);
    issue(8'h50, 8'h50, 0, 5'b10000, 0, 0);
    chk("add50_valid", result_valid, 1);
    @(negedge clk);
    chk("add50_pulse_end", result_valid, 0);
    chk("add50_hold", add_out, 8'hA0);

    // 0xFF+0x01: carry and half carry
    push(8'h00, 1, 0, 1);
    issue(8'hFF, 8'h01, 0, 5'b10000, 0, 0);
    push(8'h30, 0, 0, 0);
    issue(8'hF0, 8'h3C, 0, 5'b01000, 0, 0);    // and
    push(8'hCC, 0, 0, 0);
    issue(8'hF0, 8'h3C, 0, 5'b00100, 0, 0);    // xor
    push(8'hFC, 0, 0, 0);
    issue(8'hF0, 8'h3C, 0, 5'b00010, 0, 0);    // or
    push(8'hC0, 1, 0, 0);
    issue(8'h81, 8'h00, 1, 5'b00001, 0, 0);    // shift right, cin into MSB
    push(8'h03, 0, 0, 0);
    issue(8'h01, 8'h02, 0, 5'b10010, 0, 0);    // sums beats ors

    // Strobe with no select: no latch, no pulse
    issue(8'h77, 8'h77, 1, 5'b00000, 0, 0);
    chk("nosel_valid", result_valid, 0);
    chk("nosel_hold", add_out, 8'h03);

    // daa+dsa together behave as binary; daa on a logic op is ignored
    push(8'h41, 0, 0, 1);
    issue(8'h19, 8'h28, 0, 5'b10000, 1, 1);
    chk("both_adj_busy", busy, 0);
    push(8'h08, 0, 0, 0);
    issue(8'h19, 8'h28, 0, 5'b01000, 1, 0);
    chk("and_daa_busy", busy, 0);

    // Back-to-back strobes
    push(8'h02, 0, 0, 0);
    push(8'hFF, 0, 0, 0);
    @(negedge clk);
    drive(8'h01, 8'h01, 0, 5'b10000, 0, 0);
    @(negedge clk);
    chk("b2b_first_valid", result_valid, 1);
    drive(8'h0F, 8'hF0, 0, 5'b00010, 0, 0);
    @(negedge clk);
    idle_in();
    chk("b2b_second_valid", result_valid, 1);
    @(negedge clk);
    chk("b2b_end", result_valid, 0);

`ifdef DECIMAL_MODE_EN
    // Decimal add 19+28 -> raw 41 (hc) -> 47
    push(8'h47, 0, 0, 1);
    issue(8'h19, 8'h28, 0, 5'b10000, 1, 0);
    chk("daa_busy", busy, 1);
    chk("daa_raw", {add_out, hc, result_valid}, {8'h41, 1'b1, 1'b0});
    @(negedge clk);
    chk("daa_done", {busy, result_valid}, 2'b01);

    // Decimal subtract 10-01: raw 0F c=1 h=0 -> 09; strobe during busy ignored
    push(8'h09, 1, 0, 0);
    issue(8'h10, 8'hFE, 1, 5'b10000, 0, 1);
    chk("dsa_busy", busy, 1);
    chk("dsa_raw", {add_out, acr, hc}, {8'h0F, 1'b1, 1'b0});
    drive(8'h01, 8'h01, 0, 5'b10000, 0, 0);
    @(negedge clk);
    idle_in();
    chk("dsa_done", {busy, result_valid}, 2'b01);
    @(negedge clk);
    chk("busy_strobe_ignored", {result_valid, add_out}, {1'b0, 8'h09});

    // Reset mid-correction
    issue(8'h19, 8'h28, 0, 5'b10000, 1, 0);
    chk("pre_reset_busy", busy, 1);
    #2 reset = 1'b0;
    #1 chk("async_reset", {add_out, acr, avr, hc, result_valid, busy}, {8'h00, 5'b0});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_quiet1", {result_valid, busy}, 2'b00);
    @(negedge clk);
    chk("post_reset_quiet2", {result_valid, busy}, 2'b00);
`else
    // Without decimal mode daa is ignored: binary result in one cycle
    push(8'h41, 0, 0, 1);
    issue(8'h19, 8'h28, 0, 5'b10000, 1, 0);
    chk("daa_ignored_valid", {busy, result_valid}, 2'b01);
    push(8'h0F, 1, 0, 0);
    issue(8'h10, 8'hFE, 1, 5'b10000, 0, 1);
    chk("dsa_ignored_valid", {busy, result_valid}, 2'b01);

    // Asynchronous reset between edges
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("async_reset", {add_out, acr, avr, hc, result_valid, busy}, {8'h00, 5'b0});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_quiet", {result_valid, busy}, 2'b00);
`endif

    // First strobe after reset behaves as from IDLE
    push(8'h03, 0, 0, 0);
    issue(8'h01, 8'h02, 0, 5'b10000, 0, 0);
    chk("after_reset_valid", result_valid, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_adder_hold.md
Name: alu_adder_hold

Overview:
- 6502-compatible ALU plus adder hold register (ADD) with registered carry (ACR), overflow (AVR) and half-carry (HC).
- Directly downstream of the B input register: consumes its 8-bit output on b_in, and the A input register on a_in.
- Latches one result per alu_enable strobe. The hold value feeds the SB/ADL bus muxes elsewhere.
- Optional two-stage BCD correction path for decimal add/subtract.

Parameters:
- WIDTH, 8, datapath width. Decimal correction is only defined for 8.
- HOLD_RESET, 8'h00, reset value of add_out.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- a_in  input  WIDTH  A input register value.
- b_in  input  WIDTH  B input register value; caller supplies ~DB for subtraction.
- alu_enable  input  1  latch strobe for the current operation.
- sums  input  1  select add.
- ands  input  1  select AND.
- eors  input  1  select XOR.
- ors  input  1  select OR.
- srs  input  1  select shift right.
- i_addc  input  1  carry in; also the shifted-in MSB for srs.
- daa  input  1  decimal add adjust; valid only with sums.
- dsa  input  1  decimal subtract adjust; valid only with sums.
- add_out  output  WIDTH  adder hold register.
- acr  output  1  registered carry out.
- avr  output  1  registered overflow.
- hc  output  1  registered half carry (carry out of bit 3).
- result_valid  output  1  one-cycle pulse when add_out and the flags hold a final result.
- busy  output  1  decimal correction in progress.

Behaviour:
- Reset: add_out=HOLD_RESET; acr=avr=hc=0; result_valid=0; busy=0; state=IDLE. Reset is asynchronous and overrides everything, including mid-correction (the correction is discarded).
- States: IDLE and CORRECT. CORRECT exists only when DECIMAL_MODE_EN is defined.
- Operation select priority: sums > ands > eors > ors > srs. If alu_enable=1 with no select asserted, no latch occurs and result_valid stays 0.
- sums: r = a_in + b_in + i_addc, computed WIDTH+1 wide.
  - add_out = r[7:0]; acr = r[8].
  - avr = (a_in[7]==b_in[7]) && (r[7]!=a_in[7]).
  - hc = carry out of bit 3 of (a_in[3:0] + b_in[3:0] + i_addc).
- ands/eors/ors: bitwise result of a_in and b_in; acr=avr=hc=0.
- srs: add_out = {i_addc, a_in[7:1]}; acr = a_in[0]; avr=hc=0.
- Binary latency: result latched on the clk edge where alu_enable=1 in IDLE. result_valid pulses high for the following cycle only. add_out and the flags hold until the next latch.
- Back-to-back alu_enable in IDLE: each cycle latches, and result_valid stays high for consecutive cycles.
- daa and dsa both set: treated as binary (no correction).
- daa or dsa with a non-sums op: ignored.

Optional Feature:
- Macro: DECIMAL_MODE_EN.
- Defined:
  - IDLE → CORRECT when alu_enable, sums and exactly one of daa/dsa are asserted.
  - Latch edge: the raw binary result and flags are latched; busy=1; result_valid is not pulsed.
  - In CORRECT, on the next edge:
    - daa: if hc or low nibble >9, add 6 to the byte (carry propagates into the high nibble). Then if acr or high nibble >9, add 0x60 mod 256 and set acr=1.
    - dsa: if hc=0, low nibble -= 6 mod 16 with no borrow into the high nibble. If acr=0, high nibble -= 6 mod 16.
    - avr and hc keep their raw values.
  - Exit: return to IDLE with busy=0; result_valid pulses the following cycle. Total latency is 2 edges.
  - alu_enable asserted while busy=1 is ignored.
- Undefined (NES 2A03 behaviour): daa/dsa ignored; all ops complete in 1 cycle; busy tied to 0; no CORRECT state.

Test Plan:
- sums a=0x50 b=0x50 cin=0 → next cycle add_out=0x A0, acr=0, avr=1, hc=0, result_valid pulses for exactly 1 cycle.
- sums a=0xFF b=0x01 cin=0 → add_out=0x00, acr=1, avr=0, hc=1; then ands a=0xF0 b=0x3C → add_out=0x30, all flags 0.
- srs a=0x81 cin=1 → add_out=0xC0, acr=1; priority check: sums+ors asserted together on a=0x01 b=0x02 → add_out=0x03 via the add path, acr=0.
- DECIMAL_MODE_EN: sums+daa a=0x19 b=0x28 cin=0 → busy=1 for 1 cycle with raw add_out=0x41, hc=1; then add_out=0x47, acr=0, result_valid 2 cycles after the strobe. Without the macro: add_out=0x41, result_valid 1 cycle after the strobe.
- DECIMAL_MODE_EN: sums+dsa a=0x10 b=0xFE cin=1 → raw 0x0F, acr=1, hc=0 → corrected add_out=0x09, acr=1. A second alu_enable issued while busy is ignored.
- Drive reset=0 mid-CORRECT (asynchronously, between edges) → add_out=0x00, flags=0, busy=0 immediately; no result_valid after release; the next strobe behaves as from IDLE.
